// File: rtl/cdc_pkg.sv
// Shared types and default widths for the toggle-handshake CDC receiver.
package cdc_pkg;

    localparam int unsigned CDC_DATA_W = 8;
    localparam int unsigned CDC_CNT_W  = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        VALID = 1'b1
    } cdc_rx_state_t;

endpackage

// File: rtl/cdc_toggle_rx_if.sv
// Bundle of source-side toggle/data signals and local valid/ready output signals.
interface cdc_toggle_rx_if #(
    parameter int unsigned N  = cdc_pkg::CDC_DATA_W,
    parameter int unsigned CW = cdc_pkg::CDC_CNT_W
);

    logic          req_tgl_async;
    logic [N-1:0]  data_async;
    logic          ack_tgl;
    logic [N-1:0]  out_data;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] xfer_cnt;
    logic          proto_err;

    // Source and consumer side: drives request, data and ready.
    modport master (
        output req_tgl_async,
        output data_async,
        output out_ready,
        input  ack_tgl,
        input  out_data,
        input  out_valid,
        input  xfer_cnt,
        input  proto_err
    );

    // Receiver side.
    modport slave (
        input  req_tgl_async,
        input  data_async,
        input  out_ready,
        output ack_tgl,
        output out_data,
        output out_valid,
        output xfer_cnt,
        output proto_err
    );

endinterface

// File: rtl/sync_n_DFF.sv
// Multi-stage flip-flop synchronizer with asynchronous active-low clear.
module sync_n_DFF #(
    parameter int unsigned W      = 1,
    parameter int unsigned STAGES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [STAGES-1:0][W-1:0] sync_q;

    // Shift the asynchronous input through the synchronizer chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= d_i;
            for (int unsigned i = 1; i < STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/cdc_toggle_rx.sv
// Receive side of a two-phase bundled-data CDC: sync request toggle,
// capture held data, offer it on valid/ready, return ack toggle.
module cdc_toggle_rx
    import cdc_pkg::*;
#(
    parameter int unsigned N  = CDC_DATA_W,
    parameter int unsigned CW = CDC_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    cdc_toggle_rx_if.slave    bus
);

    cdc_rx_state_t state_q;
    logic          req_s;
    logic          req_seen_q;
    logic          ack_q;
    logic [N-1:0]  data_q;
    logic          valid_q;
    logic [CW-1:0] cnt_q;
    logic          err_q;
    logic          new_req_c;

    // Request toggle enters the local domain through two flops.
    sync_n_DFF #(.W(1), .STAGES(2)) u_req_sync (
        .clk   (clk),
        .rst_n (rst),
        .d_i   (bus.req_tgl_async),
        .q_o   (req_s)
    );

    assign new_req_c = (req_s != req_seen_q);

    // Handshake FSM; data bus is sampled only when a new request is taken in IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            req_seen_q <= 1'b0;
            ack_q      <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (new_req_c) begin
                        data_q     <= bus.data_async;
                        req_seen_q <= req_s;
                        valid_q    <= 1'b1;
                        state_q    <= VALID;
                    end
                end
                VALID: begin
                    // Extra toggle stays pending in req_s and is served after this word.
                    if (new_req_c) begin
                        err_q <= 1'b1;
                    end
                    if (bus.out_ready) begin
                        valid_q <= 1'b0;
                        ack_q   <= ~ack_q;
                        cnt_q   <= cnt_q + CW'(1);
                        state_q <= IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.ack_tgl   = ack_q;
    assign bus.out_data  = data_q;
    assign bus.out_valid = valid_q;
    assign bus.xfer_cnt  = cnt_q;
    assign bus.proto_err = err_q;

endmodule

// File: tb/tb_cdc_toggle_rx.sv
// Self-checking bench for cdc_toggle_rx (counter width reduced to 4 for wrap testing).
module tb_cdc_toggle_rx;

    localparam int unsigned N  = 8;
    localparam int unsigned CW = 4;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   exp_cnt;     // transfers completed since last reset
    logic req_lvl;     // source-side request level

    cdc_toggle_rx_if #(.N(N), .CW(CW)) bus ();

    cdc_toggle_rx #(.N(N), .CW(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle; sample/drive 1ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic toggle_req(input logic [N-1:0] d);
        bus.data_async    = d;
        req_lvl           = ~req_lvl;
        bus.req_tgl_async = req_lvl;
    endtask

    task automatic wait_valid(input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            if (bus.out_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        if (bus.out_valid === 1'b1) ok = 1'b1;
    endtask

    task automatic do_reset();
        rst               = 1'b0;
        req_lvl           = 1'b0;
        bus.req_tgl_async = 1'b0;
        bus.out_ready     = 1'b0;
        exp_cnt           = 0;
        step();
        step();
        rst = 1'b1;
        step();
    endtask

    task automatic test_reset();
        rst               = 1'b1;
        req_lvl           = 1'b0;
        bus.req_tgl_async = 1'b0;
        bus.data_async    = '0;
        bus.out_ready     = 1'b0;
        #2;
        rst = 1'b0;
        step();
        step();
        checks++;
        if ({bus.out_valid, bus.ack_tgl, bus.proto_err} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags got %b exp 000", {bus.out_valid, bus.ack_tgl, bus.proto_err});
        end
        checks++;
        if (bus.out_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_data got %0h exp 0", bus.out_data);
        end
        checks++;
        if (bus.xfer_cnt !== 4'd0) begin
            errors++;
            $display("FAIL reset_cnt got %0d exp 0", bus.xfer_cnt);
        end
        rst     = 1'b1;
        exp_cnt = 0;
        step();
    endtask

    task automatic test_single();
        bus.out_ready = 1'b1;
        toggle_req(8'h3C);
        step();
        step();
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_early_valid got %b exp 0", bus.out_valid);
        end
        step();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h3C) begin
            errors++;
            $display("FAIL single_valid got v=%b d=%0h exp v=1 d=3c", bus.out_valid, bus.out_data);
        end
        checks++;
        if (bus.ack_tgl !== 1'b0) begin
            errors++;
            $display("FAIL single_ack_before got %b exp 0", bus.ack_tgl);
        end
        step();
        exp_cnt++;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.ack_tgl !== 1'b1 || bus.xfer_cnt !== 4'(exp_cnt)) begin
            errors++;
            $display("FAIL single_handshake got v=%b ack=%b cnt=%0d exp v=0 ack=1 cnt=%0d",
                     bus.out_valid, bus.ack_tgl, bus.xfer_cnt, exp_cnt % 16);
        end
        bus.out_ready = 1'b0;
        step();
    endtask

    task automatic test_backpressure();
        logic [N-1:0] w;
        logic         ack0;
        bit           ok;
        w    = 8'($urandom);
        ack0 = bus.ack_tgl;
        bus.out_ready = 1'b0;
        toggle_req(w);
        wait_valid(8, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL bp_valid_timeout got 0 exp 1");
        end
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== w || bus.ack_tgl !== ack0) begin
                errors++;
                $display("FAIL bp_hold cyc %0d got v=%b d=%0h ack=%b exp v=1 d=%0h ack=%b",
                         i, bus.out_valid, bus.out_data, bus.ack_tgl, w, ack0);
            end
        end
        bus.out_ready = 1'b1;
        step();
        exp_cnt++;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.ack_tgl !== ~ack0 || bus.xfer_cnt !== 4'(exp_cnt)) begin
            errors++;
            $display("FAIL bp_release got v=%b ack=%b cnt=%0d exp v=0 ack=%b cnt=%0d",
                     bus.out_valid, bus.ack_tgl, bus.xfer_cnt, ~ack0, exp_cnt % 16);
        end
        step();
        step();
        checks++;
        if (bus.ack_tgl !== ~ack0 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_single_ack got ack=%b v=%b exp ack=%b v=0", bus.ack_tgl, bus.out_valid, ~ack0);
        end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [N-1:0] words[4];
        bit           ok;
        words = '{8'h01, 8'h02, 8'h03, 8'h04};
        do_reset();
        bus.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            toggle_req(words[k]);
            wait_valid(8, ok);
            checks++;
            if (!ok || bus.out_data !== words[k]) begin
                errors++;
                $display("FAIL b2b_word %0d got ok=%0d d=%0h exp %0h", k, ok, bus.out_data, words[k]);
            end
            step();
            exp_cnt++;
            checks++;
            if (bus.ack_tgl !== 1'(exp_cnt & 1)) begin
                errors++;
                $display("FAIL b2b_ack %0d got %b exp %0d", k, bus.ack_tgl, exp_cnt & 1);
            end
        end
        checks++;
        if (bus.xfer_cnt !== 4'd4 || bus.ack_tgl !== 1'b0 || bus.proto_err !== 1'b0) begin
            errors++;
            $display("FAIL b2b_end got cnt=%0d ack=%b err=%b exp cnt=4 ack=0 err=0",
                     bus.xfer_cnt, bus.ack_tgl, bus.proto_err);
        end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_violation();
        bit ok;
        do_reset();
        bus.out_ready = 1'b0;
        toggle_req(8'h11);
        wait_valid(8, ok);
        checks++;
        if (!ok || bus.proto_err !== 1'b0) begin
            errors++;
            $display("FAIL viol_first got ok=%0d err=%b exp ok=1 err=0", ok, bus.proto_err);
        end
        toggle_req(8'h22);
        step();
        step();
        step();
        checks++;
        if (bus.proto_err !== 1'b1 || bus.out_data !== 8'h11 || bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL viol_flag got err=%b d=%0h v=%b exp err=1 d=11 v=1",
                     bus.proto_err, bus.out_data, bus.out_valid);
        end
        bus.out_ready = 1'b1;
        step();
        exp_cnt++;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.xfer_cnt !== 4'(exp_cnt)) begin
            errors++;
            $display("FAIL viol_hs1 got v=%b cnt=%0d exp v=0 cnt=%0d", bus.out_valid, bus.xfer_cnt, exp_cnt);
        end
        step();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h22) begin
            errors++;
            $display("FAIL viol_second got v=%b d=%0h exp v=1 d=22", bus.out_valid, bus.out_data);
        end
        step();
        exp_cnt++;
        checks++;
        if (bus.xfer_cnt !== 4'd2 || bus.proto_err !== 1'b1) begin
            errors++;
            $display("FAIL viol_end got cnt=%0d err=%b exp cnt=2 err=1", bus.xfer_cnt, bus.proto_err);
        end
        bus.out_ready = 1'b0;
        step();
        step();
        checks++;
        if (bus.proto_err !== 1'b1) begin
            errors++;
            $display("FAIL viol_sticky got %b exp 1", bus.proto_err);
        end
    endtask

    // Random data and random ready; scoreboard of expected words in order.
    task automatic test_wrap();
        logic [N-1:0] expq[$];
        logic [N-1:0] w;
        logic [N-1:0] d_pre;
        logic [N-1:0] e;
        logic         v_pre;
        logic         rdy;
        bit           done;
        do_reset();
        for (int k = 0; k < 16; k++) begin
            w = 8'($urandom);
            expq.push_back(w);
            toggle_req(w);
            done = 1'b0;
            for (int c = 0; c < 60 && !done; c++) begin
                rdy           = 1'($urandom_range(0, 1));
                bus.out_ready = rdy;
                v_pre         = bus.out_valid;
                d_pre         = bus.out_data;
                step();
                if (v_pre && rdy) begin
                    done = 1'b1;
                    e    = expq.pop_front();
                    exp_cnt++;
                    checks++;
                    if (d_pre !== e || bus.xfer_cnt !== 4'(exp_cnt) || bus.ack_tgl !== 1'(exp_cnt & 1)) begin
                        errors++;
                        $display("FAIL wrap_xfer %0d got d=%0h cnt=%0d ack=%b exp d=%0h cnt=%0d ack=%0d",
                                 k, d_pre, bus.xfer_cnt, bus.ack_tgl, e, exp_cnt % 16, exp_cnt & 1);
                    end
                end
            end
            checks++;
            if (!done) begin
                errors++;
                $display("FAIL wrap_timeout %0d got 0 exp 1", k);
            end
        end
        bus.out_ready = 1'b0;
        checks++;
        if (bus.xfer_cnt !== 4'd0 || bus.proto_err !== 1'b0) begin
            errors++;
            $display("FAIL wrap_end got cnt=%0d err=%b exp cnt=0 err=0", bus.xfer_cnt, bus.proto_err);
        end
    endtask

    task automatic test_reset_mid_valid();
        bit ok;
        bus.out_ready = 1'b0;
        toggle_req(8'hA5);
        wait_valid(8, ok);
        checks++;
        if (!ok || bus.out_data !== 8'hA5) begin
            errors++;
            $display("FAIL rstmid_setup got ok=%0d d=%0h exp d=a5", ok, bus.out_data);
        end
        #2;
        rst               = 1'b0;
        req_lvl           = 1'b0;
        bus.req_tgl_async = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== 8'h00 || bus.ack_tgl !== 1'b0 ||
            bus.xfer_cnt !== 4'd0 || bus.proto_err !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_async got v=%b d=%0h ack=%b cnt=%0d err=%b exp all 0",
                     bus.out_valid, bus.out_data, bus.ack_tgl, bus.xfer_cnt, bus.proto_err);
        end
        step();
        rst     = 1'b1;
        exp_cnt = 0;
        for (int i = 0; i < 4; i++) step();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.xfer_cnt !== 4'd0) begin
            errors++;
            $display("FAIL rstmid_idle got v=%b cnt=%0d exp v=0 cnt=0", bus.out_valid, bus.xfer_cnt);
        end
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        exp_cnt        = 0;
        bus.data_async = '0;
        test_reset();
        test_single();
        test_backpressure();
        test_back_to_back();
        test_violation();
        test_wrap();
        test_reset_mid_valid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
